vmem0_seq: RTL and testbench

Access sequencer for the level-1 virtual memory map: the writer/initiator end of the map RAM's `vm0rp`/`vm0wp` port. It accepts single-entry map read and write requests from the memory-control/microcode side and drives the map RAM's address, write data and strobes. It reads results back from the RAM's registered `vmap` output. Because the map RAM has no reset, the block also runs a full-table clear sweep after reset and on command.

---
 rtl/vmem0_pkg.sv | 20 ++
 rtl/vmem0_seq.sv | 127 ++++++++++++
 tb/tb_vmem0_seq.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmem0_pkg.sv
// Shared constants and FSM encoding for the level-1 virtual memory map sequencer,
// the map RAM and their benches.
package vmem0_pkg;

  localparam int unsigned VMEM0_ADDR_WIDTH = 11;
  localparam int unsigned VMEM0_DATA_WIDTH = 5;
  localparam int unsigned VMEM0_DEPTH      = 2048;

  // Entry value meaning "level-2 block not mapped".
  localparam logic [VMEM0_DATA_WIDTH-1:0] VMEM0_CLEAR_VALUE = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP,
    ST_CLEAR
  } vmem0_state_e;

endpackage

// File: rtl/vmem0_seq.sv
// Access sequencer for the level-1 virtual memory map RAM: single-entry reads and
// writes from microcode plus a full-table clear sweep after reset and on command.
module vmem0_seq
  import vmem0_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = VMEM0_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH     = VMEM0_DATA_WIDTH,
  parameter int unsigned           DEPTH          = VMEM0_DEPTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = VMEM0_CLEAR_VALUE,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_adr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  clear_start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] map_adr,
  output logic [DATA_WIDTH-1:0] map_wdata,
  output logic                  vm0rp,
  output logic                  vm0wp,
  input  logic [DATA_WIDTH-1:0] vmap
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  vmem0_state_e          state_q, state_d;
  logic                  clear_pending_q, clear_pending_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] map_adr_q, map_adr_d;
  logic [DATA_WIDTH-1:0] map_wdata_q, map_wdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  busy_q, busy_d;
  logic                  vm0rp_q, vm0rp_d;
  logic                  vm0wp_q, vm0wp_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    map_adr_d       = map_adr_q;
    map_wdata_d     = map_wdata_q;
    // A clear request during a sweep is dropped so the sweep is never extended.
    clear_pending_d = clear_pending_q | (clear_start && (state_q != ST_CLEAR));

    case (state_q)
      ST_IDLE: begin
        if (clear_pending_q) begin
          state_d     = ST_CLEAR;
          cnt_d       = '0;
          map_adr_d   = '0;
          map_wdata_d = CLEAR_VALUE;
        end else if (req_valid && req_ready_q) begin
          map_adr_d = req_adr;
          if (req_write) begin
            state_d     = ST_WRITE;
            map_wdata_d = req_data;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ:  state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      ST_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d         = ST_IDLE;
          clear_pending_d = 1'b0;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          map_adr_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    req_ready_d = (state_d == ST_IDLE) && !clear_pending_d;
    vm0wp_d     = (state_d == ST_WRITE) || (state_d == ST_CLEAR);
    vm0rp_d     = (state_d == ST_READ);
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      clear_pending_q <= CLEAR_ON_RESET;
      cnt_q           <= '0;
      map_adr_q       <= '0;
      map_wdata_q     <= '0;
      req_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      vm0rp_q         <= 1'b0;
      vm0wp_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      cnt_q           <= cnt_d;
      map_adr_q       <= map_adr_d;
      map_wdata_q     <= map_wdata_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      busy_q          <= busy_d;
      vm0rp_q         <= vm0rp_d;
      vm0wp_q         <= vm0wp_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  // vmap is already registered by the RAM, so the result is passed through.
  assign rsp_data  = rsp_valid_q ? vmap : '0;
  assign busy      = busy_q;
  assign map_adr   = map_adr_q;
  assign map_wdata = map_wdata_q;
  assign vm0rp     = vm0rp_q;
  assign vm0wp     = vm0wp_q;

endmodule

// File: tb/tb_vmem0_seq.sv
// Bench for vmem0_seq: a map RAM stand-in, a transaction-schedule reference model
// checked every cycle, and directed plus random traffic.
module tb_vmem0_seq;

  localparam logic [4:0] CLEARV = 5'b11111;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, clear_start;
  logic [10:0] req_adr;
  logic [4:0]  req_data;
  logic        req_ready, rsp_valid, busy, vm0rp, vm0wp;
  logic [4:0]  rsp_data, map_wdata;
  logic [10:0] map_adr;
  logic [4:0]  vmap = '0;

  int vectors = 0;
  int miscompares = 0;
  int wp_count = 0;
  int busy_count = 0;
  int rsp_count = 0;

  always #5 clk = ~clk;

  vmem0_seq dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_adr    (req_adr),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .clear_start(clear_start),
    .busy       (busy),
    .map_adr    (map_adr),
    .map_wdata  (map_wdata),
    .vm0rp      (vm0rp),
    .vm0wp      (vm0wp),
    .vmap       (vmap)
  );

  // Map RAM stand-in: no reset, registered read output.
  logic [4:0] ram [0:2047];
  always @(posedge clk) begin
    if (vm0wp) ram[map_adr] <= map_wdata;
    if (vm0rp) vmap <= ram[map_adr];
  end

  // Reference model: a queue of expected output cycles per transaction.
  typedef struct packed {
    logic        ready, rp, wp, rv, busy, last;
    logic [10:0] adr;
    logic [4:0]  wdata, rdata;
  } exp_t;

  exp_t       cur;
  exp_t       sched[$];
  bit         pending;
  logic [4:0] model_mem [0:2047];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sched.delete();
      cur     = '0;
      pending = 1'b1;
      for (int i = 0; i < 2048; i++) model_mem[i] = CLEARV;
    end else begin
      bit   p_old;
      exp_t rec;
      p_old = pending;
      if (cur.last) pending = 1'b0;
      else if (clear_start && !cur.busy) pending = 1'b1;
      if (!(cur.rp || cur.wp || cur.rv)) begin
        if (p_old) begin
          for (int i = 0; i < 2048; i++) begin
            rec = '0; rec.wp = 1'b1; rec.busy = 1'b1; rec.adr = 11'(i);
            rec.wdata = CLEARV; rec.last = (i == 2047);
            sched.push_back(rec);
            model_mem[i] = CLEARV;
          end
        end else if (cur.ready && req_valid) begin
          if (req_write) begin
            rec = '0; rec.wp = 1'b1; rec.adr = req_adr; rec.wdata = req_data;
            sched.push_back(rec);
            model_mem[req_adr] = req_data;
          end else begin
            rec = '0; rec.rp = 1'b1; rec.adr = req_adr;
            sched.push_back(rec);
            rec = '0; rec.rv = 1'b1; rec.rdata = model_mem[req_adr];
            sched.push_back(rec);
          end
        end
      end
      if (sched.size() > 0) cur = sched.pop_front();
      else begin
        cur = '0;
        cur.ready = !pending;
      end
    end
  end

  task automatic compare_cycle();
    bit bad;
    bad = 1'b0;
    vectors++;
    if (!reset) begin
      if ({req_ready, rsp_valid, busy, vm0rp, vm0wp, map_adr, map_wdata, rsp_data} !== 26'd0) bad = 1'b1;
    end else begin
      if ({req_ready, vm0rp, vm0wp, rsp_valid, busy} !== {cur.ready, cur.rp, cur.wp, cur.rv, cur.busy}) bad = 1'b1;
      if ((cur.rp || cur.wp) && (map_adr !== cur.adr)) bad = 1'b1;
      if (cur.wp && (map_wdata !== cur.wdata)) bad = 1'b1;
      if (cur.rv && (rsp_data !== cur.rdata)) bad = 1'b1;
    end
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL cycle_check t=%0t got rdy=%b rp=%b wp=%b rv=%b busy=%b adr=%h wd=%h rd=%h required rdy=%b rp=%b wp=%b rv=%b busy=%b adr=%h wd=%h rd=%h (rst_n=%b)",
               $time, req_ready, vm0rp, vm0wp, rsp_valid, busy, map_adr, map_wdata, rsp_data,
               cur.ready, cur.rp, cur.wp, cur.rv, cur.busy, cur.adr, cur.wdata, cur.rdata, reset);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h required=%0h t=%0t", name, got, expv, $time);
    end
  endtask

  task automatic check_zero(input string name);
    checkOutput(name, {6'd0, req_ready, rsp_valid, busy, vm0rp, vm0wp, map_adr, map_wdata, rsp_data}, 32'd0);
  endtask

  // Leaves the caller just after a rising edge.
  task automatic wait_ready(input string name, input int limit);
    int n;
    n = 0;
    while (!req_ready && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, req_ready, 1);
  endtask

  task automatic applyStimulus(input bit wr, input logic [10:0] a, input logic [4:0] d, input bit with_clear);
    wait_ready("accept_wait", 4000);
    req_valid = 1'b1; req_write = wr; req_adr = a; req_data = d; clear_start = with_clear;
    @(posedge clk); #1;
    req_valid = 1'b0; clear_start = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [10:0] a, input logic [4:0] expv, input bit with_clear);
    applyStimulus(1'b0, a, 5'd0, with_clear);
    @(negedge clk);
    checkOutput({name, "_rp"}, vm0rp, 1);
    @(negedge clk);
    checkOutput({name, "_rv"}, rsp_valid, 1);
    checkOutput({name, "_data"}, rsp_data, expv);
    @(posedge clk); #1;
  endtask

  initial begin
    int w0, b0, r0, acc, n;
    bit rdy;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; clear_start = 1'b0;
    req_adr = '0; req_data = '0;
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
        if (vm0wp) wp_count++;
        if (busy) busy_count++;
        if (rsp_valid) rsp_count++;
      end
    join_none

    #12 check_zero("reset_state");
    #10 reset = 1'b1;
    w0 = wp_count; b0 = busy_count;
    wait_ready("reset_sweep_done", 2200);
    checkOutput("reset_sweep_writes", wp_count - w0, 2048);
    checkOutput("reset_sweep_busy", busy_count - b0, 2048);
    read_check("rd1234", 11'd1234, CLEARV, 1'b0);

    applyStimulus(1'b1, 11'h2A5, 5'h13, 1'b0);
    @(negedge clk);
    checkOutput("wr2a5_wp", vm0wp, 1);
    checkOutput("wr2a5_adr", map_adr, 11'h2A5);
    checkOutput("wr2a5_data", map_wdata, 5'h13);
    @(posedge clk); #1;
    read_check("rd2a5", 11'h2A5, 5'h13, 1'b0);

    // Back-to-back alternating write/read with valid held high.
    wait_ready("b2b_wait", 20);
    req_valid = 1'b1; req_write = 1'b1; req_adr = 11'h010; req_data = 5'($urandom);
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        req_write = ~req_write;
        req_data  = 5'($urandom);
      end
    end
    req_valid = 1'b0;
    checkOutput("b2b_accepts", acc, 20);

    // Clear colliding with an accepted read, then a redundant clear mid-sweep.
    applyStimulus(1'b1, 11'd5, 5'h07, 1'b0);
    read_check("collide_rd", 11'd5, 5'h07, 1'b1);
    w0 = wp_count;
    n = 0;
    while (!busy && n < 10) begin @(posedge clk); #1; n++; end
    checkOutput("collide_busy", busy, 1);
    repeat (500) @(posedge clk);
    #1 clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    wait_ready("collide_done", 3000);
    checkOutput("collide_writes", wp_count - w0, 2048);
    read_check("collide_after", 11'd5, CLEARV, 1'b0);

    // Reset in the middle of a commanded sweep.
    clear_start = 1'b1;
    @(posedge clk); #1 clear_start = 1'b0;
    n = 0;
    while (!(vm0wp && map_adr == 11'd700) && n < 1000) begin @(posedge clk); #1; n++; end
    checkOutput("sweep_reach_700", map_adr, 11'd700);
    #2 reset = 1'b0;
    #1 check_zero("async_reset_sweep");
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("restart_wp", vm0wp, 1);
    checkOutput("restart_adr", map_adr, 11'd0);
    checkOutput("restart_busy", busy, 1);
    @(posedge clk); #1;
    wait_ready("restart_done", 2200);

    // Reset while the read strobe is high: that read must never respond.
    applyStimulus(1'b0, 11'h2A5, 5'd0, 1'b0);
    checkOutput("midread_rp", vm0rp, 1);
    r0 = rsp_count;
    #2 reset = 1'b0;
    #1 check_zero("async_reset_read");
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    wait_ready("midread_done", 2200);
    checkOutput("midread_no_rsp", rsp_count - r0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      req_valid   = ($urandom_range(0, 3) != 0);
      req_write   = 1'($urandom_range(0, 1));
      req_adr     = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
      req_data    = 5'($urandom);
      clear_start = ($urandom_range(0, 799) == 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; clear_start = 1'b0;
    wait_ready("random_drain", 2300);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
